ahb_slv_mem: RTL and testbench
==============================

Name: ahb_slv_mem

Overview:
- Parametrised synthesizable AHB-Lite slave with an internal word-organised memory, runtime-programmable wait states and a two-cycle ERROR response.
- Used as the RTL endpoint behind the AHB slave bus in SoC testbenches and as a scratch SRAM in the fabric.
- Generalises the slave port to any data width and memory depth, and adds wait-state and error-response behaviour.

Parameters:
- DATA_WIDTH, 32, HWDATA/HRDATA width; one of 32, 64, 128.
- ADDR_WIDTH, 32, HADDR width.
- MEM_DEPTH, 1024, memory depth in DATA_WIDTH words; power of two.
- BASE_ADDR, 0, byte address of word 0; aligned to MEM_DEPTH*DATA_WIDTH/8.
- WAIT_WIDTH, 4, width of wait_cfg.

Ports:
- hclk  in  1  bus clock; all logic on rising edge.
- hreset  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_WIDTH  byte address.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size, 2^HSIZE bytes.
- HBURST  in  3  burst type; not used for decoding.
- HPROT  in  4  protection; not used.
- HWDATA  in  DATA_WIDTH  write data, valid in the data phase.
- HREADY_IN  in  1  bus HREADY.
- wait_cfg  in  WAIT_WIDTH  wait states inserted per OKAY transfer; sampled in the address phase.
- HRDATA  out  DATA_WIDTH  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (synchronous, hreset=1 at a rising edge):
  - HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE, wait counter=0.
  - Any pending transfer is dropped; a pending write is not committed.
  - Memory contents are not reset.
- Address-phase accept: HSEL & HREADY_IN & HTRANS[1] at a rising edge.
  - Registers HADDR, HWRITE, HSIZE and the wait count.
- IDLE, BUSY, or no accept: next data phase is OKAY, zero wait, no memory access.
- Error check at accept. The transfer is ERROR if any of these holds:
  - HADDR-BASE_ADDR >= MEM_DEPTH*DATA_WIDTH/8;
  - 2^HSIZE > DATA_WIDTH/8;
  - HADDR is not aligned to 2^HSIZE.
- States: IDLE, WAIT, DATA, ERR1, ERR2.
- IDLE: on an OKAY accept, go to WAIT if wait count > 0, else DATA. On an error accept, go to ERR1.
- WAIT: HREADYOUT=0, HRESP=0. Decrement the counter; go to DATA when it reaches 0. Data-phase latency is 1+wait_cfg cycles.
- DATA: HREADYOUT=1, HRESP=0.
  - Write: the HWDATA lanes selected by HSIZE and the low HADDR bits (little-endian) are committed at the closing edge.
  - Read: HRDATA holds the full addressed word.
  - A new accept in the same cycle is pipelined: go straight to WAIT, DATA or ERR1; otherwise go to IDLE.
- ERR1: HREADYOUT=0, HRESP=1, no memory access. Address-phase signals are ignored because HREADY_IN=0.
- ERR2: HREADYOUT=1, HRESP=1. A new accept is legal in this cycle, and the master may cancel to IDLE.
- Read-after-write: a read accepted in the same cycle as the closing DATA cycle of a write to the same word must return the merged new data (forwarding required at zero wait).
- Address index: word = (HADDR-BASE_ADDR) >> log2(DATA_WIDTH/8). Upper bits beyond the range are covered by the error check, never wrapped.
- HRDATA holds its last value outside read data phases.
- HSEL low with HREADY_IN=1 never starts a transfer, whatever HTRANS is.

Test Plan:
- Reset, then wait_cfg=0: NONSEQ write 0xDEADBEEF to BASE+0x10, then read BASE+0x10 back-to-back -> write data phase 1 cycle; read returns 0xDEADBEEF one cycle after the read address phase (forwarding path).
- wait_cfg=3: read BASE+0x0 -> HREADYOUT low for exactly 3 cycles, then high with data and HRESP=0.
- Byte write 0xAA to BASE+0x13 (HSIZE=0, 32-bit) over word 0x11223344 -> readback 0xAA223344.
- Access to BASE+MEM_DEPTH*4 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); memory unchanged. Halfword at BASE+0x1 -> same two-cycle ERROR.
- INCR4 SEQ burst of writes 1,2,3,4 at wait_cfg=1, with BUSY inserted after beat 2 -> each beat has 1 wait state, BUSY gets a zero-wait OKAY, readback is 1,2,3,4.
- Assert hreset during a WAIT cycle of a write -> next cycle HREADYOUT=1, HRESP=0, target word unchanged.

Source files
------------

// File: rtl/ahb_slv_mem.sv
// ahb_slv_mem -- AHB-Lite slave fronting a word-organised internal memory.
//
// Each OKAY transfer is stretched by wait_cfg wait states, sampled in the
// address phase. Out-of-range, oversized or misaligned transfers get the
// two-cycle ERROR response and never touch the memory.
//
// Ports
//   hclk, hreset        bus clock, synchronous active-high reset
//   HSEL, HADDR,        address phase: select, byte address,
//   HTRANS, HWRITE,     transfer type, direction,
//   HSIZE, HBURST,      size (2^HSIZE bytes), burst type (unused),
//   HPROT               protection (unused)
//   HWDATA              write data, valid in the data phase
//   HREADY_IN           bus HREADY; gates the address phase
//   wait_cfg            wait states per OKAY transfer
//   HRDATA              read data; holds between read data phases
//   HREADYOUT, HRESP    slave ready, 0 = OKAY / 1 = ERROR
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transfer in its data phase; ready for an address phase
// WAIT   | OKAY transfer stalled; counter runs down to the data cycle
// DATA   | closing data cycle: write commits, read data on HRDATA
// ERR1   | first ERROR cycle, HREADYOUT low
// ERR2   | second ERROR cycle, HREADYOUT high; may accept a new transfer
module ahb_slv_mem #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    MEM_DEPTH  = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                    WAIT_WIDTH = 4
) (
   input  logic                  hclk,
   input  logic                  hreset,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   input  logic                  HREADY_IN,
   input  logic [WAIT_WIDTH-1:0] wait_cfg,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int LANE_W = $clog2(NBYTES);
   localparam int IDX_W  = $clog2(MEM_DEPTH);
   localparam int MEM_BW = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH:0] MEM_BYTES = MEM_BW'(MEM_DEPTH * NBYTES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_open;

   logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
   logic [IDX_W-1:0]      r_idx;
   logic [LANE_W-1:0]     r_lane;
   logic [2:0]            r_size;
   logic                  r_write;
   logic [WAIT_WIDTH-1:0] r_wcnt;
   logic [DATA_WIDTH-1:0] r_rdata;

   logic [ADDR_WIDTH-1:0] w_offset;
   logic [IDX_W-1:0]      w_idx;
   logic [LANE_W-1:0]     w_align_mask;
   logic                  w_accept;
   logic                  w_take;
   logic                  w_err;
   logic                  w_ok;
   logic                  w_wait_done;
   logic                  w_commit;
   logic                  w_rd_fwd;
   logic                  w_rd_load;
   logic [DATA_WIDTH-1:0] w_cur;
   logic [DATA_WIDTH-1:0] w_merged;
   logic [DATA_WIDTH-1:0] w_rd_word;
   logic                  w_unused;

   assign w_unused = ^{HBURST, HPROT, HTRANS[0]};

   // Offsets below BASE_ADDR wrap to huge values and fall out of range.
   assign w_offset     = HADDR - BASE_ADDR;
   assign w_idx        = w_offset[LANE_W +: IDX_W];
   assign w_align_mask = (LANE_W'(1) << HSIZE) - LANE_W'(1);
   assign w_accept     = HSEL & HREADY_IN & HTRANS[1];
   assign w_err        = ({1'b0, w_offset} >= MEM_BYTES)
                       | (HSIZE > 3'(LANE_W))
                       | ((HADDR[LANE_W-1:0] & w_align_mask) != '0);

   always_ff @(posedge hclk) begin
      if (hreset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      HREADYOUT   = 1'b1;
      HRESP       = 1'b0;
      w_open      = 1'b0;
      case (r_state)
         S_IDLE: w_open = 1'b1;
         S_WAIT: begin
            HREADYOUT = 1'b0;
            if (w_wait_done) w_state_nxt = S_DATA;
         end
         S_DATA: w_open = 1'b1;
         S_ERR1: begin
            HREADYOUT   = 1'b0;
            HRESP       = 1'b1;
            w_state_nxt = S_ERR2;
         end
         S_ERR2: begin
            HRESP  = 1'b1;
            w_open = 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_open) begin
         if (!w_accept)             w_state_nxt = S_IDLE;
         else if (w_err)            w_state_nxt = S_ERR1;
         else if (wait_cfg != '0)   w_state_nxt = S_WAIT;
         else                       w_state_nxt = S_DATA;
      end
   end

   assign w_take      = w_open & w_accept;
   assign w_ok        = w_take & ~w_err;
   assign w_wait_done = (r_wcnt <= WAIT_WIDTH'(1));
   assign w_commit    = (r_state == S_DATA) & r_write;

   // Byte lanes belong to the transfer when they sit in the same
   // size-aligned block as the transfer's low address bits.
   always_comb begin
      w_cur    = r_mem[r_idx];
      w_merged = w_cur;
      for (int b = 0; b < NBYTES; b++) begin
         if ((LANE_W'(b) >> r_size) == (r_lane >> r_size)) begin
            w_merged[8*b +: 8] = HWDATA[8*b +: 8];
         end
      end
   end

   // A zero-wait read accepted while a write to the same word closes
   // must see the merged word, not the stale memory contents.
   assign w_rd_fwd  = w_commit & (r_idx == w_idx);
   assign w_rd_load = (w_ok & ~HWRITE & (wait_cfg == '0))
                    | ((r_state == S_WAIT) & w_wait_done & ~r_write);

   always_comb begin
      if (r_state == S_WAIT) begin
         w_rd_word = r_mem[r_idx];
      end else if (w_rd_fwd) begin
         w_rd_word = w_merged;
      end else begin
         w_rd_word = r_mem[w_idx];
      end
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         r_idx   <= '0;
         r_lane  <= '0;
         r_size  <= '0;
         r_write <= 1'b0;
         r_wcnt  <= '0;
         r_rdata <= '0;
      end else begin
         if (w_take) begin
            r_idx   <= w_idx;
            r_lane  <= HADDR[LANE_W-1:0];
            r_size  <= HSIZE;
            r_write <= HWRITE;
            r_wcnt  <= wait_cfg;
         end else if (r_state == S_WAIT) begin
            r_wcnt  <= r_wcnt - WAIT_WIDTH'(1);
         end
         if (w_rd_load) r_rdata <= w_rd_word;
      end
   end

   always_ff @(posedge hclk) begin
      if (!hreset && w_commit) begin
         r_mem[r_idx] <= w_merged;
      end
   end

   assign HRDATA = r_rdata;

endmodule

// File: tb/tb_ahb_slv_mem.sv
module tb_ahb_slv_mem;

   localparam int          MEM_DEPTH = 64;
   localparam int          MEM_BYTES = MEM_DEPTH * 4;
   localparam logic [31:0] BASE      = 32'h0000_1000;

   typedef struct packed {
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wcfg;
   } xfer_t;

   logic        hclk = 1'b0;
   logic        hreset;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic [31:0] HWDATA;
   logic        HREADY_IN;
   logic [3:0]  wait_cfg;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [2:0]  hburst_v = 3'b000;

   xfer_t       q[$];
   int          res_waits[$];
   logic        res_low[$];
   logic        res_resp[$];
   logic [31:0] res_data[$];

   logic [7:0]  mem_m [MEM_BYTES];

   always #5 hclk = ~hclk;

   assign HREADY_IN = HREADYOUT;

   ahb_slv_mem #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(32),
      .MEM_DEPTH (MEM_DEPTH),
      .BASE_ADDR (BASE),
      .WAIT_WIDTH(4)
   ) dut (
      .hclk     (hclk),
      .hreset   (hreset),
      .HSEL     (HSEL),
      .HADDR    (HADDR),
      .HTRANS   (HTRANS),
      .HWRITE   (HWRITE),
      .HSIZE    (HSIZE),
      .HBURST   (HBURST),
      .HPROT    (HPROT),
      .HWDATA   (HWDATA),
      .HREADY_IN(HREADY_IN),
      .wait_cfg (wait_cfg),
      .HRDATA   (HRDATA),
      .HREADYOUT(HREADYOUT),
      .HRESP    (HRESP)
   );

   function automatic xfer_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                                input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wcfg);
      xfer_t x;
      x.sel = sel; x.trans = trans; x.wr = wr; x.size = size;
      x.addr = addr; x.wdata = wdata; x.wcfg = wcfg;
      return x;
   endfunction

   // Reference model: byte-addressed memory; each transfer is applied in bus
   // order and yields its expected wait count, error flag and read word.
   function automatic void model_step(input xfer_t x, output int ew, output logic ee,
                                      output logic chk, output logic [31:0] ed);
      longint off;
      int     nb;
      int     b;
      ew = 0; ee = 1'b0; chk = 1'b0; ed = '0;
      if (!(x.sel && x.trans[1])) return;
      off = longint'(x.addr) - longint'(BASE);
      nb  = 1 << x.size;
      if (off < 0 || off >= MEM_BYTES || nb > 4 || (off % nb) != 0) begin
         ee = 1'b1;
         ew = 1;
         return;
      end
      ew = int'(x.wcfg);
      if (x.wr) begin
         for (int i = 0; i < nb; i++) begin
            b = int'(off) + i;
            mem_m[b] = x.wdata[8*(b%4) +: 8];
         end
      end else begin
         chk = 1'b1;
         b = int'(off) & ~3;
         for (int i = 0; i < 4; i++) ed[8*i +: 8] = mem_m[b+i];
      end
   endfunction

   function automatic logic [31:0] model_word(input int off);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = mem_m[(off & ~3) + i];
      return w;
   endfunction

   // Pipelined AHB master: plays q, records one data-phase result per entry.
   // Called and returns at posedge+1.
   task automatic run_seq();
      int   ai = 0;
      int   dp = 0;
      int   budget = 0;
      int   w = 0;
      logic low = 1'b0;
      logic dpv = 1'b0;
      res_waits.delete(); res_low.delete(); res_resp.delete(); res_data.delete();
      while ((ai < q.size() || dpv) && budget < 5000) begin
         if (ai < q.size()) begin
            HSEL = q[ai].sel; HTRANS = q[ai].trans; HWRITE = q[ai].wr;
            HSIZE = q[ai].size; HADDR = q[ai].addr; wait_cfg = q[ai].wcfg;
         end else begin
            HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0;
            HADDR = '0; wait_cfg = '0;
         end
         HBURST = hburst_v;
         HWDATA = dpv ? q[dp].wdata : 32'h0;
         if (HREADYOUT) begin
            if (dpv) begin
               res_waits.push_back(w); res_low.push_back(low);
               res_resp.push_back(HRESP); res_data.push_back(HRDATA);
            end
            w = 0; low = 1'b0;
            dpv = (ai < q.size());
            dp  = ai;
            if (ai < q.size()) ai++;
         end else begin
            w++;
            low = low | HRESP;
         end
         @(posedge hclk); #1;
         budget++;
      end
      if (budget >= 5000) begin
         n_chk++; n_fail++;
         $display("FAIL run_seq timeout: completed %0d of %0d transfers", res_waits.size(), q.size());
      end
   endtask

   task automatic test_reset();
      hreset = 1'b1;
      repeat (3) @(posedge hclk);
      #1;
      hreset = 1'b0;
      n_chk++;
      if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin
         n_fail++;
         $display("FAIL reset: got rdy=%b resp=%b rdata=%08h, expected 1 0 00000000", HREADYOUT, HRESP, HRDATA);
      end
   endtask

   task automatic test_fill();
      int ew; logic ee, chk; logic [31:0] ed;
      q.delete();
      for (int i = 0; i < MEM_DEPTH; i++) q.push_back(mk(1, 2'b10, 1, 3'd2, BASE + 32'(4*i), $urandom, 4'd0));
      for (int i = 0; i < 16; i++) q.push_back(mk(1, 2'b10, 0, 3'd2, BASE + 32'(4*$urandom_range(0, MEM_DEPTH-1)), 32'h0, 4'($urandom_range(0, 2))));
      run_seq();
      for (int i = 0; i < q.size(); i++) begin
         model_step(q[i], ew, ee, chk, ed);
         n_chk++;
         if (res_waits[i] !== ew || res_low[i] !== ee || res_resp[i] !== ee) begin
            n_fail++;
            $display("FAIL fill resp #%0d: got waits=%0d err1=%b resp=%b, expected waits=%0d err=%b", i, res_waits[i], res_low[i], res_resp[i], ew, ee);
         end
         if (chk) begin
            n_chk++;
            if (res_data[i] !== ed) begin
               n_fail++;
               $display("FAIL fill rdata #%0d: got %08h expected %08h", i, res_data[i], ed);
            end
         end
      end
   endtask

   task automatic test_forwarding();
      int ew; logic ee, chk; logic [31:0] ed;
      q.delete();
      q.push_back(mk(1, 2'b10, 1, 3'd2, BASE + 32'h10, 32'hDEAD_BEEF, 4'd0));
      q.push_back(mk(1, 2'b10, 0, 3'd2, BASE + 32'h10, 32'h0, 4'd0));
      q.push_back(mk(1, 2'b10, 1, 3'd0, BASE + 32'h11, 32'h0000_5A00, 4'd0));
      q.push_back(mk(1, 2'b10, 0, 3'd2, BASE + 32'h10, 32'h0, 4'd0));
      run_seq();
      n_chk++;
      if (res_waits[0] !== 0 || res_waits[1] !== 0 || res_data[1] !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL fwd direct: got waits=%0d/%0d rdata=%08h, expected 0/0 deadbeef", res_waits[0], res_waits[1], res_data[1]);
      end
      for (int i = 0; i < q.size(); i++) begin
         model_step(q[i], ew, ee, chk, ed);
         n_chk++;
         if (res_waits[i] !== ew || res_low[i] !== ee || res_resp[i] !== ee || (chk && res_data[i] !== ed)) begin
            n_fail++;
            $display("FAIL fwd #%0d: got waits=%0d resp=%b rdata=%08h, expected waits=%0d err=%b rdata=%08h", i, res_waits[i], res_resp[i], res_data[i], ew, ee, ed);
         end
      end
   endtask

   task automatic test_wait();
      int ew; logic ee, chk; logic [31:0] ed;
      q.delete();
      q.push_back(mk(1, 2'b10, 0, 3'd2, BASE, 32'h0, 4'd3));
      run_seq();
      model_step(q[0], ew, ee, chk, ed);
      n_chk++;
      if (res_waits[0] !== 3 || res_low[0] !== 1'b0 || res_resp[0] !== 1'b0 || res_data[0] !== ed) begin
         n_fail++;
         $display("FAIL wait3 read: got waits=%0d resp=%b rdata=%08h, expected 3 0 %08h", res_waits[0], res_resp[0], res_data[0], ed);
      end
   endtask

   task automatic test_byte_lanes();
      int ew; logic ee, chk; logic [31:0] ed;
      q.delete();
      q.push_back(mk(1, 2'b10, 1, 3'd2, BASE + 32'h10, 32'h1122_3344, 4'd0));
      q.push_back(mk(1, 2'b10, 1, 3'd0, BASE + 32'h13, 32'hAA00_0000, 4'd0));
      q.push_back(mk(1, 2'b10, 0, 3'd2, BASE + 32'h10, 32'h0, 4'd0));
      q.push_back(mk(1, 2'b10, 1, 3'd1, BASE + 32'h16, 32'hBEEF_0000, 4'd1));
      q.push_back(mk(1, 2'b10, 0, 3'd2, BASE + 32'h14, 32'h0, 4'd2));
      run_seq();
      n_chk++;
      if (res_data[2] !== 32'hAA22_3344) begin
         n_fail++;
         $display("FAIL byte write: got %08h expected aa223344", res_data[2]);
      end
      for (int i = 0; i < q.size(); i++) begin
         model_step(q[i], ew, ee, chk, ed);
         n_chk++;
         if (res_waits[i] !== ew || res_resp[i] !== ee || (chk && res_data[i] !== ed)) begin
            n_fail++;
            $display("FAIL lanes #%0d: got waits=%0d resp=%b rdata=%08h, expected waits=%0d err=%b rdata=%08h", i, res_waits[i], res_resp[i], res_data[i], ew, ee, ed);
         end
      end
   endtask

   task automatic test_error();
      int ew; logic ee, chk; logic [31:0] ed;
      logic [31:0] w0;
      w0 = model_word(0);
      q.delete();
      q.push_back(mk(1, 2'b10, 1, 3'd2, BASE + 32'(MEM_BYTES), 32'h1234_5678, 4'd2));
      q.push_back(mk(1, 2'b10, 0, 3'd2, BASE + 32'(MEM_BYTES), 32'h0, 4'd0));
      q.push_back(mk(1, 2'b10, 1, 3'd1, BASE + 32'h1, 32'hFFFF_FFFF, 4'd0));
      q.push_back(mk(1, 2'b10, 1, 3'd3, BASE, 32'hFFFF_FFFF, 4'd0));
      q.push_back(mk(1, 2'b10, 1, 3'd2, BASE - 32'h4, 32'hFFFF_FFFF, 4'd0));
      q.push_back(mk(1, 2'b10, 0, 3'd2, BASE, 32'h0, 4'd0));
      run_seq();
      n_chk++;
      if (res_waits[2] !== 1 || res_low[2] !== 1'b1 || res_resp[2] !== 1'b1 || res_data[5] !== w0) begin
         n_fail++;
         $display("FAIL error direct: got waits=%0d err1=%b err2=%b word0=%08h, expected 1 1 1 %08h", res_waits[2], res_low[2], res_resp[2], res_data[5], w0);
      end
      for (int i = 0; i < q.size(); i++) begin
         model_step(q[i], ew, ee, chk, ed);
         n_chk++;
         if (res_waits[i] !== ew || res_low[i] !== ee || res_resp[i] !== ee || (chk && res_data[i] !== ed)) begin
            n_fail++;
            $display("FAIL error #%0d: got waits=%0d err1=%b resp=%b rdata=%08h, expected waits=%0d err=%b rdata=%08h", i, res_waits[i], res_low[i], res_resp[i], res_data[i], ew, ee, ed);
         end
      end
   endtask

   task automatic test_burst_busy();
      int ew; logic ee, chk; logic [31:0] ed;
      q.delete();
      hburst_v = 3'b011;
      q.push_back(mk(1, 2'b10, 1, 3'd2, BASE + 32'h20, 32'd1, 4'd1));
      q.push_back(mk(1, 2'b11, 1, 3'd2, BASE + 32'h24, 32'd2, 4'd1));
      q.push_back(mk(1, 2'b01, 1, 3'd2, BASE + 32'h28, 32'd0, 4'd1));
      q.push_back(mk(1, 2'b11, 1, 3'd2, BASE + 32'h28, 32'd3, 4'd1));
      q.push_back(mk(1, 2'b11, 1, 3'd2, BASE + 32'h2C, 32'd4, 4'd1));
      for (int k = 0; k < 4; k++) q.push_back(mk(1, 2'b10, 0, 3'd2, BASE + 32'h20 + 32'(4*k), 32'h0, 4'd0));
      run_seq();
      hburst_v = 3'b000;
      for (int k = 0; k < 4; k++) begin
         n_chk++;
         if (res_data[5+k] !== 32'(k+1)) begin
            n_fail++;
            $display("FAIL burst readback beat %0d: got %08h expected %08h", k, res_data[5+k], 32'(k+1));
         end
      end
      for (int i = 0; i < q.size(); i++) begin
         model_step(q[i], ew, ee, chk, ed);
         n_chk++;
         if (res_waits[i] !== ew || res_resp[i] !== ee || (chk && res_data[i] !== ed)) begin
            n_fail++;
            $display("FAIL burst #%0d: got waits=%0d resp=%b rdata=%08h, expected waits=%0d err=%b rdata=%08h", i, res_waits[i], res_resp[i], res_data[i], ew, ee, ed);
         end
      end
   endtask

   task automatic test_random();
      int ew; logic ee, chk; logic [31:0] ed;
      int r, off;
      logic [2:0] sz;
      logic [1:0] tr;
      logic [31:0] a;
      q.delete();
      for (int i = 0; i < 300; i++) begin
         r  = $urandom_range(0, 9);
         tr = (r < 1) ? 2'b00 : (r < 2) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
         r  = $urandom_range(0, 9);
         sz = (r < 9) ? 3'(r % 3) : 3'd3;
         off = $urandom_range(0, MEM_BYTES + 31);
         if ($urandom_range(0, 7) != 0) off = off & ~((1 << sz) - 1);
         a = BASE + 32'(off);
         if ($urandom_range(0, 19) == 0) a = BASE - 32'(4 * $urandom_range(1, 4));
         q.push_back(mk($urandom_range(0, 9) != 0, tr, 1'($urandom_range(0, 1)), sz, a, $urandom,
                        ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(1, 3))));
      end
      run_seq();
      for (int i = 0; i < q.size(); i++) begin
         model_step(q[i], ew, ee, chk, ed);
         n_chk++;
         if (res_waits[i] !== ew || res_low[i] !== ee || res_resp[i] !== ee || (chk && res_data[i] !== ed)) begin
            n_fail++;
            $display("FAIL random #%0d addr=%08h sz=%0d: got waits=%0d err1=%b resp=%b rdata=%08h, expected waits=%0d err=%b rdata=%08h",
                     i, q[i].addr, q[i].size, res_waits[i], res_low[i], res_resp[i], res_data[i], ew, ee, ed);
         end
      end
   endtask

   task automatic test_reset_in_wait();
      logic [31:0] old_w;
      old_w = model_word(32'h40);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2;
      HADDR = BASE + 32'h40; wait_cfg = 4'd3; HWDATA = 32'h0;
      @(posedge hclk); #1;
      HSEL = 1'b0; HTRANS = 2'b00; HWDATA = ~old_w; wait_cfg = 4'd0;
      n_chk++;
      if (HREADYOUT !== 1'b0 || HRESP !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_wait entry: got rdy=%b resp=%b, expected 0 0", HREADYOUT, HRESP);
      end
      hreset = 1'b1;
      @(posedge hclk); #1;
      hreset = 1'b0;
      n_chk++;
      if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_wait after: got rdy=%b resp=%b rdata=%08h, expected 1 0 00000000", HREADYOUT, HRESP, HRDATA);
      end
      repeat (3) begin @(posedge hclk); #1; end
      q.delete();
      q.push_back(mk(1, 2'b10, 0, 3'd2, BASE + 32'h40, 32'h0, 4'd0));
      run_seq();
      n_chk++;
      if (res_data[0] !== old_w || res_resp[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_wait word: got %08h resp=%b expected %08h 0", res_data[0], res_resp[0], old_w);
      end
   endtask

   initial begin
      hreset = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
      HSIZE = 3'd0; HBURST = 3'd0; HPROT = 4'b0011; HWDATA = '0; wait_cfg = '0;
      for (int i = 0; i < MEM_BYTES; i++) mem_m[i] = 8'h00;
      test_reset();
      test_fill();
      test_forwarding();
      test_wait();
      test_byte_lanes();
      test_error();
      test_burst_busy();
      test_random();
      test_reset_in_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
